mac_accumulator: RTL
====================

Name: mac_accumulator

Overview:
Downstream consumer of the sparse input-selector stage. It takes the matched IFM/filter non-zero byte pairs (data_valid) and the sub-chunk end strobe, multiplies each pair as signed int8, and accumulates across one or more sub-chunks into a saturating partial sum. On the final sub-chunk of an output pixel it pushes the result into a 2-entry output FIFO drained through a valid/ready handshake.

Parameters:
ACC_WIDTH, 24, accumulator and result width in bits (signed); legal range 16..32.
SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
clk_i  input  1  clock; all logic on posedge.
rst_i  input  1  synchronous active-high reset.
ifm_data_i  input  8  signed IFM non-zero byte; qualified by data_valid_i.
fil_data_i  input  8  signed filter non-zero byte; qualified by data_valid_i.
data_valid_i  input  1  pair is a valid match this cycle.
sub_chunk_end_i  input  1  current sub-chunk finishes this cycle.
last_sub_chunk_i  input  1  sampled only with sub_chunk_end_i; 1 = final sub-chunk of this output.
out_data_o  output  ACC_WIDTH  head-of-FIFO result.
out_sat_o  output  1  head result saturated or wrapped during its accumulation.
out_valid_o  output  1  FIFO non-empty.
out_ready_i  input  1  consumer accepts head when out_valid_o=1.
full_o  output  1  both FIFO entries occupied; upstream must not start a new sub-chunk.
err_drop_o  output  1  sticky; a result was dropped because the FIFO was full.

Behaviour:
- Reset: accumulator, pipeline registers, FIFO pointers and count, out_data_o, out_sat_o, out_valid_o, full_o and err_drop_o all go to 0. A reset mid-accumulation discards the partial sum. err_drop_o clears only on reset.
- Stage P (cycle N):
  - prod_r <= sext(ifm)*sext(fil), a 16-bit signed product.
  - pvld_r <= data_valid_i.
  - flush_r <= sub_chunk_end_i & last_sub_chunk_i.
  - When data_valid_i=0, prod_r is don't-care and pvld_r gates it.
  - Data and end may coincide; the coinciding pair is included in the flushed result.
- Stage A (cycle N+1):
  - sum = acc_r + (pvld_r ? sext(prod_r) : 0), computed at ACC_WIDTH+1 bits.
  - Overflow is detected when the top two bits of sum differ.
  - SATURATE=1: clamp to +(2^(ACC_WIDTH-1))-1 or -2^(ACC_WIDTH-1).
  - SATURATE=0: truncate.
  - sat_r |= overflow.
  - flush_r=0: acc_r <= sum.
  - flush_r=1: push {sum, sat_r | overflow} into the FIFO; acc_r <= 0; sat_r <= 0.
- sub_chunk_end_i with last_sub_chunk_i=0 does not alter the accumulator; accumulation continues into the next sub-chunk.
- Latency: the last pair and the final end arrive in cycle N; out_valid_o rises in cycle N+2 if the FIFO was empty.
- FIFO (depth 2, registered outputs, first-word fall-through):
  - Pop when out_valid_o & out_ready_i.
  - Push and pop in the same cycle are allowed in any state, including full: count unchanged, order preserved.
  - Push while full without a pop drops the new result, sets err_drop_o, and leaves the stored entries intact.
  - full_o = (count==2); it is registered and reflects the count after this cycle's push/pop.
- Handshake: out_data_o and out_sat_o hold stable while out_valid_o=1 and out_ready_i=0.
- Back-to-back flushes in consecutive cycles are legal, e.g. empty sub-chunks: a zero-product flush pushes 0.

Test Plan:
- Reset check: hold rst_i for 2 cycles -> all outputs 0; FIFO empty.
- Single sub-chunk:
  - Stimulus: pairs (3,4), (-2,5), (127,127); end+last with the third pair in cycle N.
  - Response: out_valid_o=1 at N+2, out_data_o=16131, out_sat_o=0.
- Multi sub-chunk: (10,10) with end and last=0, then (-1,50) with end and last=1 -> single result 50; no intermediate push.
- Saturation with ACC_WIDTH=16, SATURATE=1:
  - Stimulus: (-128,-128) twice, then flush.
  - Response: out_data_o=32767, out_sat_o=1; the next result's out_sat_o=0.
- Backpressure:
  - Stimulus: out_ready_i=0 and three flushes with results 1, 2, 3.
  - Response: full_o=1 after the second push; result 3 is dropped; err_drop_o=1.
  - Then raise out_ready_i: pops 1 then 2; out_valid_o falls.
- Reset mid-operation: accumulate (5,5), assert rst_i one cycle, then (2,3) with flush -> result 6; err_drop_o=0.

Source files
------------

// File: rtl/mac_accumulator.sv
// Signed int8 multiply-accumulate over one or more sub-chunks, with an optional saturating
// partial sum. Each finished result goes into a 2-entry first-word-fall-through output FIFO.
module mac_accumulator #(
  parameter int ACC_WIDTH = 24,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic signed [7:0]           ifm_data_i,
  input  logic signed [7:0]           fil_data_i,
  input  logic                        data_valid_i,
  input  logic                        sub_chunk_end_i,
  input  logic                        last_sub_chunk_i,
  output logic signed [ACC_WIDTH-1:0] out_data_o,
  output logic                        out_sat_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        full_o,
  output logic                        err_drop_o
);

  if (ACC_WIDTH < 16 || ACC_WIDTH > 32) begin : g_bad_width
    $error("mac_accumulator: ACC_WIDTH must be within 16..32");
  end

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Stage P: product register
  // ---------------------------------------------------------------------------
  logic signed [15:0] w_ifm_ext;
  logic signed [15:0] w_fil_ext;
  logic signed [15:0] w_prod;
  logic signed [15:0] r_prod;
  logic               r_pvld;
  logic               r_flush;

  assign w_ifm_ext = {{8{ifm_data_i[7]}}, ifm_data_i};
  assign w_fil_ext = {{8{fil_data_i[7]}}, fil_data_i};
  assign w_prod    = w_ifm_ext * w_fil_ext;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prod  <= '0;
      r_pvld  <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_prod  <= w_prod;
      r_pvld  <= data_valid_i;
      r_flush <= sub_chunk_end_i & last_sub_chunk_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage A: accumulate one bit wider so that overflow shows up in the top two bits
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_sat;
  logic signed [ACC_WIDTH:0]   w_addend;
  logic signed [ACC_WIDTH:0]   w_sum;
  logic                        w_ovf;
  logic signed [ACC_WIDTH-1:0] w_res;
  logic                        w_res_sat;

  assign w_addend  = r_pvld ? {{(ACC_WIDTH+1-16){r_prod[15]}}, r_prod} : '0;
  assign w_sum     = {r_acc[ACC_WIDTH-1], r_acc} + w_addend;
  assign w_ovf     = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
  assign w_res_sat = r_sat | w_ovf;

  always_comb begin
    w_res = w_sum[ACC_WIDTH-1:0];
    if (SATURATE && w_ovf) begin
      w_res = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (r_flush) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else begin
      r_acc <= w_res;
      r_sat <= w_res_sat;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO as a 2-entry shift structure: the head register drives the port directly.
  // ---------------------------------------------------------------------------
  logic                        w_push;
  logic                        w_pop;
  logic                        w_drop;
  logic signed [ACC_WIDTH-1:0] r_head_data;
  logic                        r_head_sat;
  logic signed [ACC_WIDTH-1:0] r_tail_data;
  logic                        r_tail_sat;
  logic [1:0]                  r_count;
  logic                        r_valid;
  logic                        r_full;
  logic                        r_err;
  logic signed [ACC_WIDTH-1:0] w_head_data_nxt;
  logic                        w_head_sat_nxt;
  logic signed [ACC_WIDTH-1:0] w_tail_data_nxt;
  logic                        w_tail_sat_nxt;
  logic [1:0]                  w_count_nxt;

  assign w_push = r_flush;
  assign w_pop  = r_valid & out_ready_i;

  always_comb begin
    w_head_data_nxt = r_head_data;
    w_head_sat_nxt  = r_head_sat;
    w_tail_data_nxt = r_tail_data;
    w_tail_sat_nxt  = r_tail_sat;
    w_count_nxt     = r_count;
    w_drop          = 1'b0;
    case (r_count)
      2'd0: begin
        if (w_push) begin
          w_head_data_nxt = w_res;
          w_head_sat_nxt  = w_res_sat;
          w_count_nxt     = 2'd1;
        end
      end
      2'd1: begin
        case ({w_push, w_pop})
          2'b11: begin
            w_head_data_nxt = w_res;
            w_head_sat_nxt  = w_res_sat;
          end
          2'b10: begin
            w_tail_data_nxt = w_res;
            w_tail_sat_nxt  = w_res_sat;
            w_count_nxt     = 2'd2;
          end
          2'b01: w_count_nxt = 2'd0;
          default: ;
        endcase
      end
      default: begin
        case ({w_push, w_pop})
          2'b11: begin
            w_head_data_nxt = r_tail_data;
            w_head_sat_nxt  = r_tail_sat;
            w_tail_data_nxt = w_res;
            w_tail_sat_nxt  = w_res_sat;
          end
          // The FIFO is full and nothing leaves this cycle, so the new result is lost.
          2'b10: w_drop = 1'b1;
          2'b01: begin
            w_head_data_nxt = r_tail_data;
            w_head_sat_nxt  = r_tail_sat;
            w_count_nxt     = 2'd1;
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head_data <= '0;
      r_head_sat  <= 1'b0;
      r_tail_data <= '0;
      r_tail_sat  <= 1'b0;
      r_count     <= 2'd0;
      r_valid     <= 1'b0;
      r_full      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_head_data <= w_head_data_nxt;
      r_head_sat  <= w_head_sat_nxt;
      r_tail_data <= w_tail_data_nxt;
      r_tail_sat  <= w_tail_sat_nxt;
      r_count     <= w_count_nxt;
      r_valid     <= (w_count_nxt != 2'd0);
      r_full      <= (w_count_nxt == 2'd2);
      r_err       <= r_err | w_drop;
    end
  end

  assign out_data_o  = r_head_data;
  assign out_sat_o   = r_head_sat;
  assign out_valid_o = r_valid;
  assign full_o      = r_full;
  assign err_drop_o  = r_err;

endmodule
